// File: rtl/l1_instruction_fill_controller.sv
// Instruction fetch front end for a 32x16 direct-mapped L1 array: tag/valid
// directory, hit path via the array read port, 4-beat line refill from L2.
module l1_instruction_fill_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LINE_WORDS = 4,
    parameter int L1_WORDS   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          FetchRequest,
    input  logic [ADDR_WIDTH-1:0]         FetchAddress,
    input  logic                          Invalidate,
    output logic                          FetchReady,
    output logic [DATA_WIDTH-1:0]         Instruction,
    output logic [15:0]                   MissCount,
    output logic                          L2Request,
    output logic [ADDR_WIDTH-1:0]         L2Address,
    input  logic                          L2Valid,
    input  logic [DATA_WIDTH-1:0]         L2Data,
    output logic                          mode,
    output logic [$clog2(L1_WORDS)-1:0]   WriteAddress,
    output logic [DATA_WIDTH-1:0]         WriteValue,
    output logic [$clog2(L1_WORDS)-1:0]   ReadAddress1,
    input  logic [DATA_WIDTH-1:0]         ReadValue1
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int L1_AW   = $clog2(L1_WORDS);
    localparam int IDX_W   = L1_AW - OFF_W;
    localparam int LINES   = L1_WORDS / LINE_WORDS;
    localparam int TAG_W   = ADDR_WIDTH - L1_AW;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q [LINES];
    logic                   tag_we;
    logic [OFF_W-1:0]       beat_q, beat_d;
    logic                   ready_q, ready_d;
    logic [DATA_WIDTH-1:0]  instr_q, instr_d;
    logic [15:0]            miss_cnt_q, miss_cnt_d;
    logic                   l2_req_q, l2_req_d;
    logic [ADDR_WIDTH-1:0]  l2_addr_q, l2_addr_d;
    logic                   mode_q, mode_d;
    logic [L1_AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_val_q, wr_val_d;
    logic [L1_AW-1:0]       rd_addr_q, rd_addr_d;

    logic [IDX_W-1:0]       idx;
    logic [OFF_W-1:0]       off;
    logic [TAG_W-1:0]       tag;
    logic                   hit;

    assign idx = addr_q[L1_AW-1:OFF_W];
    assign off = addr_q[OFF_W-1:0];
    assign tag = addr_q[ADDR_WIDTH-1:L1_AW];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        tag_we     = 1'b0;
        beat_d     = beat_q;
        ready_d    = 1'b0;
        instr_d    = instr_q;
        miss_cnt_d = miss_cnt_q;
        l2_req_d   = l2_req_q;
        l2_addr_d  = l2_addr_q;
        mode_d     = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_val_d   = wr_val_q;
        rd_addr_d  = rd_addr_q;
        case (state_q)
            IDLE: begin
                // Invalidate lands first so a same-cycle request sees an empty directory.
                if (Invalidate) valid_d = '0;
                if (FetchRequest) begin
                    addr_d    = FetchAddress;
                    rd_addr_d = FetchAddress[L1_AW-1:0];
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    instr_d = ReadValue1;
                    ready_d = 1'b1;
                    state_d = RESPOND;
                end else begin
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                    l2_req_d  = 1'b1;
                    l2_addr_d = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    beat_d    = '0;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                if (L2Valid) begin
                    mode_d    = 1'b1;
                    wr_addr_d = {idx, beat_q};
                    wr_val_d  = L2Data;
                    if (beat_q == off) instr_d = L2Data;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        l2_req_d     = 1'b0;
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        ready_d      = 1'b1;
                        state_d      = RESPOND;
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            beat_q     <= '0;
            ready_q    <= 1'b0;
            instr_q    <= '0;
            miss_cnt_q <= '0;
            l2_req_q   <= 1'b0;
            l2_addr_q  <= '0;
            mode_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_val_q   <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            beat_q     <= beat_d;
            ready_q    <= ready_d;
            instr_q    <= instr_d;
            miss_cnt_q <= miss_cnt_d;
            l2_req_q   <= l2_req_d;
            l2_addr_q  <= l2_addr_d;
            mode_q     <= mode_d;
            wr_addr_q  <= wr_addr_d;
            wr_val_q   <= wr_val_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Tags need no reset: they are meaningless while the matching valid bit is clear.
    always_ff @(posedge clk) begin
        if (!reset && tag_we) tag_q[idx] <= tag;
    end

    assign FetchReady   = ready_q;
    assign Instruction  = instr_q;
    assign MissCount    = miss_cnt_q;
    assign L2Request    = l2_req_q;
    assign L2Address    = l2_addr_q;
    assign mode         = mode_q;
    assign WriteAddress = wr_addr_q;
    assign WriteValue   = wr_val_q;
    assign ReadAddress1 = rd_addr_q;
endmodule

// File: tb/tb_l1_instruction_fill_controller.sv
// Bench for the L1 instruction fill controller: transaction-level cache model,
// per-cycle output comparison, plus literal expectations from hand calculation.
module tb_l1_instruction_fill_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        FetchRequest = 1'b0;
    logic [15:0] FetchAddress = '0;
    logic        Invalidate = 1'b0;
    logic        FetchReady;
    logic [15:0] Instruction;
    logic [15:0] MissCount;
    logic        L2Request;
    logic [15:0] L2Address;
    logic        L2Valid = 1'b0;
    logic [15:0] L2Data = '0;
    logic        mode;
    logic [4:0]  WriteAddress;
    logic [15:0] WriteValue;
    logic [4:0]  ReadAddress1;
    logic [15:0] ReadValue1;

    l1_instruction_fill_controller dut (
        .clk(clk), .reset(reset), .FetchRequest(FetchRequest), .FetchAddress(FetchAddress),
        .Invalidate(Invalidate), .FetchReady(FetchReady), .Instruction(Instruction),
        .MissCount(MissCount), .L2Request(L2Request), .L2Address(L2Address),
        .L2Valid(L2Valid), .L2Data(L2Data), .mode(mode), .WriteAddress(WriteAddress),
        .WriteValue(WriteValue), .ReadAddress1(ReadAddress1), .ReadValue1(ReadValue1)
    );

    always #5 clk = ~clk;

    // L1 array stand-in: synchronous write, combinational read
    logic [15:0] l1mem [32];
    always @(posedge clk) if (mode) l1mem[WriteAddress] <= WriteValue;
    assign ReadValue1 = l1mem[ReadAddress1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // model: directory, line contents, counter, and per-cycle expected events
    bit          mv [8];
    logic [10:0] mt [8];
    logic [15:0] md [32];
    logic [15:0] mcnt = '0;
    logic [15:0] exp_instr = '0;
    logic [15:0] exp_l2a = '0;
    bit          ex_fr [int];
    logic [20:0] ex_wr [int];
    bit          ex_l2 [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("FetchReady", 32'(FetchReady), 32'(ex_fr.exists(cyc)));
            if (FetchReady && ex_fr.exists(cyc)) begin
                chk("Instruction", 32'(Instruction), 32'(exp_instr));
                chk("MissCount", 32'(MissCount), 32'(mcnt));
            end
            chk("mode", 32'(mode), 32'(ex_wr.exists(cyc)));
            if (mode && ex_wr.exists(cyc))
                chk("write", 32'({WriteAddress, WriteValue}), 32'(ex_wr[cyc]));
            chk("L2Request", 32'(L2Request), 32'(ex_l2.exists(cyc)));
            if (L2Request) chk("L2Address", 32'(L2Address), 32'(exp_l2a));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch from IDLE; returns in the following IDLE cycle.
    // g[k] idle L2 cycles precede beat k; beat k carries base+k.
    task automatic fetch(input logic [15:0] a, input bit inv, input int g0, input int g1,
                         input int g2, input int g3, input logic [15:0] base, output int lat);
        int n, c;
        int g [4];
        logic [2:0]  idx;
        logic [10:0] tg;
        g = '{g0, g1, g2, g3};
        idx = a[4:2];
        tg  = a[15:5];
        n = cyc;
        if (inv) for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        FetchRequest = 1'b1; FetchAddress = a; Invalidate = inv;
        if (mv[idx] && mt[idx] == tg) begin
            exp_instr = md[a[4:0]];
            ex_fr[n+2] = 1'b1;
            tick();
            FetchRequest = 1'b0; Invalidate = 1'b0;
            tick(); tick();
            lat = 2;
        end else begin
            if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            exp_l2a = {a[15:2], 2'b00};
            tick();
            FetchRequest = 1'b0; Invalidate = 1'b0;
            tick();
            c = n + 2;
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < g[k]; j++) begin
                    L2Valid = 1'b0; ex_l2[c] = 1'b1; tick(); c++;
                end
                L2Valid = 1'b1; L2Data = base + 16'(k);
                ex_l2[c] = 1'b1;
                ex_wr[c+1] = {idx, 2'(k), base + 16'(k)};
                md[{idx, 2'(k)}] = base + 16'(k);
                tick(); c++;
            end
            L2Valid = 1'b0;
            mv[idx] = 1'b1; mt[idx] = tg;
            exp_instr = base + 16'(a[1:0]);
            ex_fr[c] = 1'b1;
            tick();
            lat = c - n;
        end
    endtask

    int lat, n;

    initial begin
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_outs", {FetchReady, L2Request, mode, ReadAddress1, WriteAddress, 19'd0}, 32'd0);
        chk("rst_data", {Instruction, MissCount}, 32'd0);
        tick();

        // cold miss, back-to-back beats
        fetch(16'h0021, 1'b0, 0, 0, 0, 0, 16'hA000, lat);
        chk("miss_lat", 32'(lat), 32'd6);
        chk("miss_instr", 32'(Instruction), 32'h0000A001);
        chk("miss_cnt1", 32'(MissCount), 32'd1);
        chk("l2addr", 32'(L2Address), 32'h00000020);

        // hit in the line just filled
        fetch(16'h0023, 1'b0, 0, 0, 0, 0, 16'h0, lat);
        chk("hit_lat", 32'(lat), 32'd2);
        chk("hit_raddr", 32'(ReadAddress1), 32'd3);
        chk("hit_instr", 32'(Instruction), 32'h0000A003);
        chk("hit_cnt", 32'(MissCount), 32'd1);

        // conflict miss with gapped beats, then the evicted line misses again
        fetch(16'h0421, 1'b0, 0, 1, 1, 1, 16'hB000, lat);
        chk("gap_lat", 32'(lat), 32'd9);
        chk("gap_instr", 32'(Instruction), 32'h0000B001);
        fetch(16'h0021, 1'b0, 0, 0, 0, 0, 16'hC000, lat);
        chk("evict_cnt", 32'(MissCount), 32'd3);

        // refill 0x0421, then invalidate + request together must miss
        fetch(16'h0421, 1'b0, 0, 0, 0, 0, 16'hE000, lat);
        fetch(16'h0421, 1'b1, 0, 0, 0, 0, 16'hE100, lat);
        chk("inv_lat", 32'(lat), 32'd6);
        chk("inv_cnt", 32'(MissCount), 32'd5);

        // back-to-back hits
        n = cyc;
        fetch(16'h0422, 1'b0, 0, 0, 0, 0, 16'h0, lat);
        fetch(16'h0423, 1'b0, 0, 0, 0, 0, 16'h0, lat);
        chk("b2b_period", 32'(cyc - n), 32'd6);
        chk("b2b_instr", 32'(Instruction), 32'h0000E103);

        // reset after two of four beats
        n = cyc;
        FetchRequest = 1'b1; FetchAddress = 16'h0040;
        mcnt = mcnt + 16'd1; exp_l2a = 16'h0040;
        tick(); FetchRequest = 1'b0; tick();
        L2Valid = 1'b1; L2Data = 16'hF000; ex_l2[n+2] = 1'b1; ex_wr[n+3] = {5'd0, 16'hF000}; tick();
        L2Data = 16'hF001; ex_l2[n+3] = 1'b1; ex_wr[n+4] = {5'd1, 16'hF001}; tick();
        L2Valid = 1'b0; reset = 1'b1; ex_l2[n+4] = 1'b1; tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        mcnt = '0; exp_instr = '0;
        chk("mid_rst_outs", {FetchReady, L2Request, mode, ReadAddress1, WriteAddress, 19'd0}, 32'd0);
        chk("mid_rst_data", {Instruction, MissCount}, 32'd0);
        chk("mid_rst_addr", {L2Address, WriteValue}, 32'd0);
        L2Valid = 1'b1; L2Data = 16'hF002; tick();
        L2Data = 16'hF003; tick();
        L2Valid = 1'b0; tick();
        fetch(16'h0040, 1'b0, 0, 0, 0, 0, 16'h1230, lat);
        chk("post_rst_miss", 32'(MissCount), 32'd1);
        chk("post_rst_instr", 32'(Instruction), 32'h00001230);

        // saturation
        dut.miss_cnt_q = 16'hFFFE;
        mcnt = 16'hFFFE;
        fetch(16'h0080, 1'b0, 0, 0, 0, 0, 16'h5550, lat);
        chk("sat_ffff", 32'(MissCount), 32'h0000FFFF);
        fetch(16'h00A0, 1'b0, 0, 0, 0, 0, 16'h6660, lat);
        chk("sat_hold", 32'(MissCount), 32'h0000FFFF);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
